// File: rtl/trng_pkg.sv
// Shared constants and state encoding for the TRNG entropy collection and conditioning path.
package trng_pkg;

    localparam int BLOCK_W_DEF    = 512;
    localparam int CNT_W_DEF      = 10;
    localparam int RCT_CUTOFF_DEF = 32;
    // Wide enough for any cutoff in 2..255
    localparam int RCT_RUN_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2,
        ST_FAIL    = 2'd3
    } state_e;

endpackage

// File: rtl/entropy_collector_512_if.sv
// Noise-sample input, block handshake and health status bundle between the collector and its controller.
interface entropy_collector_512_if #(
    parameter int BLOCK_W = trng_pkg::BLOCK_W_DEF,
    parameter int CNT_W   = trng_pkg::CNT_W_DEF
);
    logic               en;
    logic               vn_en;
    logic               raw_bit;
    logic               raw_valid;
    logic [BLOCK_W-1:0] block_out;
    logic               block_valid;
    logic               block_ready;
    logic [CNT_W-1:0]   bit_count;
    logic               health_fail;
    logic               clear_fail;

    modport master (
        output en, vn_en, raw_bit, raw_valid, block_ready, clear_fail,
        input  block_out, block_valid, bit_count, health_fail
    );

    modport slave (
        input  en, vn_en, raw_bit, raw_valid, block_ready, clear_fail,
        output block_out, block_valid, bit_count, health_fail
    );
endinterface

// File: rtl/vn_debias.sv
// Von Neumann pair debiaser: 01->0, 10->1, 00/11 dropped; combinational result on the pair's second sample.
// Bypass passes samples straight through and keeps the pair register empty; flush discards a half pair.
module vn_debias (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic bypass,
    input  logic in_bit,
    input  logic in_valid,
    output logic out_bit,
    output logic out_valid
);
    logic have_first;
    logic first_bit;

    assign out_valid = in_valid && (bypass || (have_first && (first_bit != in_bit)));
    assign out_bit   = bypass ? in_bit : first_bit;

    always_ff @(posedge clk) begin
        if (rst || flush || bypass) begin
            have_first <= 1'b0;
            first_bit  <= 1'b0;
        end else if (in_valid) begin
            if (!have_first) begin
                first_bit <= in_bit;
            end
            have_first <= !have_first;
        end
    end
endmodule

// File: rtl/entropy_collector_512.sv
// Packs (optionally debiased) noise bits MSB-first into a block; bits land on the sampling edge, no extra latency.
// Full block is held under valid/ready backpressure (samples dropped); repetition-count trip forces sticky FAIL.
module entropy_collector_512
    import trng_pkg::*;
#(
    parameter int BLOCK_W    = BLOCK_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int RCT_CUTOFF = RCT_CUTOFF_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    entropy_collector_512_if.slave bus
);
    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] COLLECT = ST_COLLECT;
    localparam logic [1:0] FULL    = ST_FULL;
    localparam logic [1:0] FAIL    = ST_FAIL;

    localparam logic [RCT_RUN_W-1:0] CUT_V  = RCT_RUN_W'(RCT_CUTOFF);
    localparam logic [CNT_W-1:0]     LAST_C = CNT_W'(BLOCK_W - 1);

    logic [1:0]           state;
    logic [BLOCK_W-1:0]   shreg;
    logic [CNT_W-1:0]     cnt;
    logic                 valid_q;
    logic                 fail_q;
    logic                 prev_bit;
    logic                 have_prev;
    logic [RCT_RUN_W-1:0] run_cnt;
    logic [RCT_RUN_W-1:0] run_next;

    logic sampling;
    logic same;
    logic trip;
    logic vn_in_valid;
    logic vn_flush;
    logic acc_bit;
    logic acc_valid;

    // Health test watches every raw sample in COLLECT/FULL, independent of debiasing
    always_comb begin
        sampling = bus.raw_valid && (((state == COLLECT) && bus.en) || (state == FULL));
        same     = have_prev && (bus.raw_bit == prev_bit);
        if (!same) begin
            run_next = RCT_RUN_W'(1);
        end else if (run_cnt == CUT_V) begin
            run_next = run_cnt;
        end else begin
            run_next = run_cnt + 1'b1;
        end
        trip        = sampling && (run_next == CUT_V);
        vn_in_valid = bus.raw_valid && (state == COLLECT) && bus.en;
        vn_flush    = (state != COLLECT) || !bus.en || trip;
    end

    vn_debias u_vn (
        .clk       (clk),
        .rst       (rst),
        .flush     (vn_flush),
        .bypass    (!bus.vn_en),
        .in_bit    (bus.raw_bit),
        .in_valid  (vn_in_valid),
        .out_bit   (acc_bit),
        .out_valid (acc_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            valid_q   <= 1'b0;
            fail_q    <= 1'b0;
            prev_bit  <= 1'b0;
            have_prev <= 1'b0;
            run_cnt   <= '0;
        end else begin
            if (sampling) begin
                prev_bit  <= bus.raw_bit;
                have_prev <= 1'b1;
                run_cnt   <= run_next;
            end
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        state     <= COLLECT;
                        have_prev <= 1'b0;
                        run_cnt   <= '0;
                    end
                end
                COLLECT: begin
                    if (!bus.en) begin
                        state <= IDLE;
                        shreg <= '0;
                        cnt   <= '0;
                    end else if (trip) begin
                        state   <= FAIL;
                        fail_q  <= 1'b1;
                        valid_q <= 1'b0;
                        shreg   <= '0;
                        cnt     <= '0;
                    end else if (acc_valid) begin
                        shreg <= {shreg[BLOCK_W-2:0], acc_bit};
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST_C) begin
                            state   <= FULL;
                            valid_q <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    // A trip on the handshake edge still consumes the block; clearing is identical
                    if (trip) begin
                        state   <= FAIL;
                        fail_q  <= 1'b1;
                        valid_q <= 1'b0;
                        shreg   <= '0;
                        cnt     <= '0;
                    end else if (bus.block_ready) begin
                        state   <= bus.en ? COLLECT : IDLE;
                        valid_q <= 1'b0;
                        shreg   <= '0;
                        cnt     <= '0;
                    end
                end
                FAIL: begin
                    if (bus.clear_fail) begin
                        state  <= IDLE;
                        fail_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.block_out   = shreg;
    assign bus.bit_count   = cnt;
    assign bus.block_valid = valid_q;
    assign bus.health_fail = fail_q;
endmodule
